// File: rtl/inta_sequencer_if.sv
// -----------------------------------------------------------------------------
// inta_sequencer_if
// CPU-side acknowledge/data-bus bundle for the 8259A interrupt-acknowledge
// sequencer.
//   inta_n : CPU interrupt acknowledge, active low, asynchronous to clk
//   d_out  : response byte driven onto the CPU data bus
//   d_oe   : data-bus output enable
//   busy   : an acknowledge sequence is in progress
// Modports:
//   master : the CPU side (drives inta_n, observes the response)
//   slave  : the sequencer (receives inta_n, drives the response)
// -----------------------------------------------------------------------------
interface inta_sequencer_if;
   logic       inta_n;
   logic [7:0] d_out;
   logic       d_oe;
   logic       busy;

   modport master (output inta_n, input d_out, input d_oe, input busy);
   modport slave  (input inta_n, output d_out, output d_oe, output busy);
endinterface

// File: rtl/inta_sequencer.sv
// -----------------------------------------------------------------------------
// inta_sequencer
// Clocked interrupt-acknowledge sequencer for the 8259A PIC. It synchronises
// and counts the CPU's INTA_N pulses, strobes the priority resolver to commit
// the winning request into ISR, latches the resolved vector, and drives the
// response byte for each acknowledge pulse (8086 two-pulse or 8080/8085
// three-pulse).
//
// Build option:
//   INTA_MODE_8080_EN  defined   : 8080 three-pulse support (GAP2/ACK3 states,
//                                  CALL opcode, adi address formatting).
//                      undefined : 8086 only; mode_8086, adi and addr_hi are
//                                  ignored (behaves as mode_8086 = 1).
//
// Parameters:
//   CLK_DIV_NONE : reserved, must stay 0 (no clock division).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cpu        if   slave modport: inta_n in, d_out/d_oe/busy out
//   int_req    in   INT from priority_resolver
//   int_vec    in   resolved IR index from priority_resolver
//   mode_8086  in   ICW4 uPM: 1 = 8086, 0 = 8080
//   aeoi       in   ICW4 AEOI bit
//   adi        in   ICW1 call-address interval: 1 = 4 bytes, 0 = 8 bytes
//   vec_base   in   ICW2 (8086) or 8080 low address byte
//   addr_hi    in   8080 high address byte
//   ack_strobe out  one-cycle pulse: resolver sets ISR / clears IRR
//   eoi_strobe out  one-cycle automatic-EOI request
// -----------------------------------------------------------------------------
module inta_sequencer #(
   parameter int unsigned CLK_DIV_NONE = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   inta_sequencer_if.slave     cpu,
   input  logic                int_req,
   input  logic [2:0]          int_vec,
   input  logic                mode_8086,
   input  logic                aeoi,
   input  logic                adi,
   input  logic [7:0]          vec_base,
   input  logic [7:0]          addr_hi,
   output logic                ack_strobe,
   output logic                eoi_strobe
);

   // Reserved divider setting: only the undivided clock exists.
   if (CLK_DIV_NONE != 0) begin : g_clk_div_reserved
   end

`ifdef INTA_MODE_8080_EN
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ACK1 = 3'd1,
      GAP1 = 3'd2,
      ACK2 = 3'd3,
      GAP2 = 3'd4,
      ACK3 = 3'd5,
      DONE = 3'd6
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ACK1 = 3'd1,
      GAP1 = 3'd2,
      ACK2 = 3'd3,
      DONE = 3'd6
   } state_t;
`endif

   localparam logic [7:0] CALL_OPCODE = 8'hCD;

   // --------------------------------------------------------------------------
   // INTA_N synchroniser and edge detection
   // --------------------------------------------------------------------------
   logic inta_m;
   logic inta_s;
   logic inta_p;
   logic inta_fall;
   logic inta_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inta_m <= 1'b1;
         inta_s <= 1'b1;
         inta_p <= 1'b1;
      end else begin
         inta_m <= cpu.inta_n;
         inta_s <= inta_m;
         inta_p <= inta_s;
      end
   end

   assign inta_fall = inta_p & ~inta_s;
   assign inta_rise = ~inta_p & inta_s;

   // --------------------------------------------------------------------------
   // Sequence state
   // --------------------------------------------------------------------------
   state_t     state;
   state_t     state_d;
   logic       spurious;
   logic       spurious_d;
   logic [2:0] vec_q;
   logic [2:0] vec_d;
   logic       ack_d;
   logic       eoi_d;
   logic       busy_d;
   logic       oe_d;
   logic [7:0] dout_d;
   logic       d_oe_q;
   logic [7:0] d_out_q;
   logic       busy_q;
   logic       ack_q;
   logic       eoi_q;

`ifdef INTA_MODE_8080_EN
   logic mode_q;
   logic mode_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         spurious <= 1'b0;
         vec_q    <= '0;
         ack_q    <= 1'b0;
         eoi_q    <= 1'b0;
         busy_q   <= 1'b0;
         d_oe_q   <= 1'b0;
         d_out_q  <= '0;
`ifdef INTA_MODE_8080_EN
         mode_q   <= 1'b1;
`endif
      end else begin
         state    <= state_d;
         spurious <= spurious_d;
         vec_q    <= vec_d;
         ack_q    <= ack_d;
         eoi_q    <= eoi_d;
         busy_q   <= busy_d;
         d_oe_q   <= oe_d;
         d_out_q  <= dout_d;
`ifdef INTA_MODE_8080_EN
         mode_q   <= mode_d;
`endif
      end
   end

   // Next state plus the values the registered outputs take on entering it.
   // The response byte is computed from the next-state copies of mode/vector
   // so that it is valid on the same edge that enters ACKn.
   always_comb begin
      state_d    = state;
      spurious_d = spurious;
      vec_d      = vec_q;
      ack_d      = 1'b0;
`ifdef INTA_MODE_8080_EN
      mode_d     = mode_q;
`endif

      unique case (state)
         IDLE: begin
            if (inta_fall) begin
               state_d    = ACK1;
               ack_d      = 1'b1;
               spurious_d = ~int_req;
`ifdef INTA_MODE_8080_EN
               mode_d     = mode_8086;
`endif
            end
         end
         ACK1: begin
            if (inta_rise) state_d = GAP1;
         end
         GAP1: begin
            if (inta_fall) begin
               state_d = ACK2;
               vec_d   = spurious ? 3'd7 : int_vec;
            end
         end
         ACK2: begin
            if (inta_rise) begin
`ifdef INTA_MODE_8080_EN
               state_d = mode_q ? DONE : GAP2;
`else
               state_d = DONE;
`endif
            end
         end
`ifdef INTA_MODE_8080_EN
         GAP2: begin
            if (inta_fall) state_d = ACK3;
         end
         ACK3: begin
            if (inta_rise) state_d = DONE;
         end
`endif
         DONE: begin
            // Any falling edge seen here is dropped; only IDLE starts a sequence.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // DONE always lasts exactly one cycle, so this is a single pulse.
      eoi_d  = (state_d == DONE) & aeoi & ~spurious;
      busy_d = (state_d != IDLE);

      oe_d   = 1'b0;
      dout_d = '0;
      unique case (state_d)
         ACK1: begin
`ifdef INTA_MODE_8080_EN
            if (!mode_d) begin
               oe_d   = 1'b1;
               dout_d = CALL_OPCODE;
            end
`endif
         end
         ACK2: begin
            oe_d = 1'b1;
`ifdef INTA_MODE_8080_EN
            if (mode_d) begin
               dout_d = {vec_base[7:3], vec_d};
            end else if (adi) begin
               dout_d = {vec_base[7:5], vec_d, 2'b00};
            end else begin
               dout_d = {vec_base[7:6], vec_d, 3'b000};
            end
`else
            dout_d = {vec_base[7:3], vec_d};
`endif
         end
`ifdef INTA_MODE_8080_EN
         ACK3: begin
            oe_d   = 1'b1;
            dout_d = addr_hi;
         end
`endif
         default: begin
            oe_d   = 1'b0;
            dout_d = '0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign cpu.d_out  = d_out_q;
   assign cpu.d_oe   = d_oe_q;
   assign cpu.busy   = busy_q;
   assign ack_strobe = ack_q;
   assign eoi_strobe = eoi_q;

   // Inputs not consumed by the selected build.
   logic unused_inputs;
`ifdef INTA_MODE_8080_EN
   assign unused_inputs = ^vec_base[2:0];
`else
   assign unused_inputs = ^{mode_8086, adi, addr_hi, vec_base[2:0]};
`endif

endmodule

// File: tb/tb_inta_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inta_sequencer
// Table-driven bench for inta_sequencer. Each table row describes one
// acknowledge sequence and its expected response per pulse; expected
// responses are queued when a pulse is driven and compared when the DUT's
// registered response is due (3 clk edges after the pin edge).
// -----------------------------------------------------------------------------
module tb_inta_sequencer;

   logic       clk;
   logic       rst_n;
   logic       int_req;
   logic [2:0] int_vec;
   logic       mode_8086;
   logic       aeoi;
   logic       adi;
   logic [7:0] vec_base;
   logic [7:0] addr_hi;
   logic       ack_strobe;
   logic       eoi_strobe;

   inta_sequencer_if bus ();

   inta_sequencer #(.CLK_DIV_NONE(0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu        (bus.slave),
      .int_req    (int_req),
      .int_vec    (int_vec),
      .mode_8086  (mode_8086),
      .aeoi       (aeoi),
      .adi        (adi),
      .vec_base   (vec_base),
      .addr_hi    (addr_hi),
      .ack_strobe (ack_strobe),
      .eoi_strobe (eoi_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       m86;     // mode_8086 pin value
      logic       aeoi;
      logic       adi;
      logic       req;     // int_req at pulse 1
      logic       drop;    // drop int_req after pulse 1
      logic       late;    // glitch a falling edge into DONE
      logic       rst2;    // assert reset during ACK2
      logic [2:0] vec;
      logic [7:0] vb;
      logic [7:0] ah;
      logic [7:0] b1;
      logic       oe1;
      logic [7:0] b2;
      logic [7:0] b3;
      logic       eoi;
   } vec_t;

   typedef struct packed {
      logic [7:0] d;
      logic       oe;
      logic       ack;
   } rsp_t;

   vec_t tbl[$];
   rsp_t sb[$];

   int n_cmp = 0;
   int n_bad = 0;
   int ack_cnt = 0;
   int eoi_cnt = 0;

   always @(negedge clk) begin
      if (ack_strobe === 1'b1) ack_cnt++;
      if (eoi_strobe === 1'b1) eoi_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic m86, input logic ae, input logic ad,
                               input logic req, input logic drop, input logic late,
                               input logic rst2, input logic [2:0] vec,
                               input logic [7:0] vb, input logic [7:0] ah,
                               input logic [7:0] b1, input logic oe1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic eoi);
      vec_t v;
      v.m86 = m86; v.aeoi = ae; v.adi = ad; v.req = req; v.drop = drop;
      v.late = late; v.rst2 = rst2; v.vec = vec; v.vb = vb; v.ah = ah;
      v.b1 = b1; v.oe1 = oe1; v.b2 = b2; v.b3 = b3; v.eoi = eoi;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      int   ack0;
      int   eoi0;
      int   np;
      logic eff86;
      rsp_t e;
      rsp_t r;
      bit   last;
`ifdef INTA_MODE_8080_EN
      eff86 = v.m86;
`else
      eff86 = 1'b1;
`endif
      np = eff86 ? 2 : 3;
      @(negedge clk);
      mode_8086 = v.m86; aeoi = v.aeoi; adi = v.adi; int_req = v.req;
      int_vec = v.vec; vec_base = v.vb; addr_hi = v.ah;
      ack0 = ack_cnt;
      eoi0 = eoi_cnt;
      for (int p = 0; p < np; p++) begin
         last  = (p == np - 1);
         e.d   = (p == 0) ? v.b1 : (p == 1) ? v.b2 : v.b3;
         e.oe  = (p == 0) ? v.oe1 : 1'b1;
         e.ack = (p == 0);
         sb.push_back(e);
         bus.inta_n = 1'b0;
         repeat (2) @(posedge clk);
         @(negedge clk);
         if (p == 0) begin
            chk($sformatf("v%0d_early_ack", idx), ack_strobe, 0);
            chk($sformatf("v%0d_early_busy", idx), bus.busy, 0);
         end
         @(posedge clk);
         @(negedge clk);
         r = sb.pop_front();
         chk($sformatf("v%0d_p%0d_oe", idx, p), bus.d_oe, r.oe);
         if (r.oe) chk($sformatf("v%0d_p%0d_dout", idx, p), bus.d_out, r.d);
         chk($sformatf("v%0d_p%0d_ack", idx, p), ack_strobe, r.ack);
         chk($sformatf("v%0d_p%0d_busy", idx, p), bus.busy, 1);
         if (p == 1 && v.rst2) begin
            rst_n = 1'b0;
            #1;
            chk($sformatf("v%0d_rst_oe", idx), bus.d_oe, 0);
            chk($sformatf("v%0d_rst_busy", idx), bus.busy, 0);
            bus.inta_n = 1'b1;
            #2;
            @(negedge clk);
            rst_n = 1'b1;
            repeat (6) @(negedge clk);
            chk($sformatf("v%0d_rst_eoi", idx), eoi_cnt - eoi0, 0);
            chk($sformatf("v%0d_rst_acks", idx), ack_cnt - ack0, 1);
            chk($sformatf("v%0d_rst_idle", idx), bus.busy, 0);
            return;
         end
         repeat (3) @(negedge clk);
         if (p == 0) chk($sformatf("v%0d_ack_width", idx), ack_strobe, 0);
         if (p == 0 && v.drop) int_req = 1'b0;
         bus.inta_n = 1'b1;
         if (last && v.late) begin
            @(posedge clk);
            @(negedge clk);
            bus.inta_n = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
         end else begin
            repeat (3) @(posedge clk);
            @(negedge clk);
         end
         chk($sformatf("v%0d_p%0d_rise_oe", idx, p), bus.d_oe, 0);
         if (last) begin
            chk($sformatf("v%0d_done_eoi", idx), eoi_strobe, v.eoi);
            chk($sformatf("v%0d_done_busy", idx), bus.busy, 1);
         end
         if (last && v.late) begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_late_idle", idx), bus.busy, 0);
            bus.inta_n = 1'b1;
         end
         repeat (4) @(negedge clk);
      end
      chk($sformatf("v%0d_ack_count", idx), ack_cnt - ack0, 1);
      chk($sformatf("v%0d_eoi_count", idx), eoi_cnt - eoi0, v.eoi);
      chk($sformatf("v%0d_end_busy", idx), bus.busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1);
   end

   initial begin
      //             m86 ae ad rq dr lt r2 vec  vb     ah     b1    oe1  b2     b3     eoi
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 3'd3, 8'h40, 8'h00, 8'h00, 0, 8'h43, 8'h00, 0));
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 3'd3, 8'h40, 8'h00, 8'h00, 0, 8'h43, 8'h00, 1));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3'd5, 8'h08, 8'h00, 8'h00, 0, 8'h0F, 8'h00, 0));
      tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 3'd6, 8'hF8, 8'h00, 8'h00, 0, 8'hFE, 8'h00, 1));
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 3'd3, 8'h40, 8'h00, 8'h00, 0, 8'h43, 8'h00, 0));
      tbl.push_back(mk(1, 1, 0, 1, 0, 1, 0, 3'd3, 8'h40, 8'h00, 8'h00, 0, 8'h43, 8'h00, 1));
`ifdef INTA_MODE_8080_EN
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 3'd5, 8'hE0, 8'h12, 8'hCD, 1, 8'hF4, 8'h12, 0));
      tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 3'd2, 8'hC0, 8'h34, 8'hCD, 1, 8'hD0, 8'h34, 1));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 3'd1, 8'hE0, 8'h56, 8'hCD, 1, 8'hFC, 8'h56, 0));
      tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 3'd1, 8'hA8, 8'h99, 8'h00, 0, 8'hA9, 8'h00, 0));
`else
      // mode_8086/adi low must be ignored in the 8086-only build.
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3'd3, 8'h40, 8'h77, 8'h00, 0, 8'h43, 8'h00, 0));
`endif

      bus.inta_n = 1'b1;
      rst_n = 1'b0;
      int_req = 1'b0; int_vec = '0; mode_8086 = 1'b1; aeoi = 1'b0; adi = 1'b0;
      vec_base = '0; addr_hi = '0;
      repeat (3) @(negedge clk);
      chk("reset_dout", bus.d_out, 8'h00);
      chk("reset_oe", bus.d_oe, 0);
      chk("reset_ack", ack_strobe, 0);
      chk("reset_eoi", eoi_strobe, 0);
      chk("reset_busy", bus.busy, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      foreach (tbl[i]) run_vec(tbl[i], i);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
